// File: rtl/i2c_probe_arbiter.sv
// i2c_probe_arbiter
//   Shares one I2C address-probe engine between N_REQ requesters with
//   round-robin arbitration. It issues the probe strobe and address,
//   supervises completion with a timeout, and routes the ACK/NACK (or
//   timeout) result back to the winning requester.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   req[N_REQ]     per-requester level request, held until its rsp_stb
//   req_adr        7-bit address per requester, requester i at [7i+6:7i]
//   gnt[N_REQ]     one-hot grant, high from issue through the response cycle
//   rsp_stb[N_REQ] one-cycle response pulse to the granted requester
//   rsp_ack        1 = device ACKed (valid with rsp_stb, held until next response)
//   rsp_to         1 = probe timed out (valid with rsp_stb, held likewise)
//   bsy            arbiter not idle
//   p_stb, p_adr   probe engine start pulse and address
//   p_bsy          probe engine busy; blocks new grants
//   p_o_stb        probe engine result strobe
//   p_o_ack        probe engine ACK result
module i2c_probe_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 100000,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] req_adr,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_stb,
    output logic               rsp_ack,
    output logic               rsp_to,
    output logic               bsy,
    output logic               p_stb,
    output logic [6:0]         p_adr,
    input  logic               p_bsy,
    input  logic               p_o_stb,
    input  logic               p_o_ack
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      idx, idx_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_REQ-1:0]   gnt_nxt, rsp_stb_nxt;
    logic               rsp_ack_nxt, rsp_to_nxt, bsy_nxt, p_stb_nxt;
    logic [6:0]         p_adr_nxt;

    // Round-robin pick: first asserted request scanning upward from
    // rr_ptr+1. Scanning from the far end down lets the nearest hit win.
    logic               pick_vld;
    logic [IW-1:0]      pick_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            int c;
            c = (int'(rr_ptr) + k) % N_REQ;
            if (req[c]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(c);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        rr_ptr_nxt  = rr_ptr;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt;
        rsp_stb_nxt = '0;
        rsp_ack_nxt = rsp_ack;
        rsp_to_nxt  = rsp_to;
        p_stb_nxt   = 1'b0;
        p_adr_nxt   = p_adr;

        case (state)
            IDLE: begin
                if (pick_vld && !p_bsy) begin
                    idx_nxt           = pick_idx;
                    p_adr_nxt         = req_adr[7*int'(pick_idx) +: 7];
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    p_stb_nxt         = 1'b1;
                    // Counter starts running in the strobe cycle, so the
                    // response lands exactly TIMEOUT cycles after p_stb.
                    cnt_nxt           = CNT_W'(TIMEOUT - 1);
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                // The engine cannot answer in its own strobe cycle.
                cnt_nxt   = cnt - 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (p_o_stb) begin
                    // A result on the final counter cycle still wins.
                    rsp_ack_nxt      = p_o_ack;
                    rsp_to_nxt       = 1'b0;
                    rsp_stb_nxt[idx] = 1'b1;
                    state_nxt        = RESP;
                end else if (cnt == '0) begin
                    rsp_ack_nxt      = 1'b0;
                    rsp_to_nxt       = 1'b1;
                    rsp_stb_nxt[idx] = 1'b1;
                    state_nxt        = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                rr_ptr_nxt = idx;
                gnt_nxt    = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        bsy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            rr_ptr  <= IW'(N_REQ - 1);
            cnt     <= '0;
            gnt     <= '0;
            rsp_stb <= '0;
            rsp_ack <= 1'b0;
            rsp_to  <= 1'b0;
            bsy     <= 1'b0;
            p_stb   <= 1'b0;
            p_adr   <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            rr_ptr  <= rr_ptr_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            rsp_stb <= rsp_stb_nxt;
            rsp_ack <= rsp_ack_nxt;
            rsp_to  <= rsp_to_nxt;
            bsy     <= bsy_nxt;
            p_stb   <= p_stb_nxt;
            p_adr   <= p_adr_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_probe_arbiter.sv
// Self-checking bench for i2c_probe_arbiter: directed cases plus randomized
// transactions, checked against a transaction-level round-robin model.
module tb_i2c_probe_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [7*N-1:0]   req_adr;
    logic [N-1:0]     gnt, rsp_stb;
    logic             rsp_ack, rsp_to, bsy, p_stb;
    logic [6:0]       p_adr;
    logic             p_bsy, p_o_stb, p_o_ack;

    i2c_probe_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_adr(req_adr),
        .gnt(gnt), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack), .rsp_to(rsp_to),
        .bsy(bsy), .p_stb(p_stb), .p_adr(p_adr),
        .p_bsy(p_bsy), .p_o_stb(p_o_stb), .p_o_ack(p_o_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int last_gnt = N - 1;   // model: index of last served requester
    logic [6:0] adr [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last_gnt + k) % N]) return (last_gnt + k) % N;
        return -1;
    endfunction

    // One probe transaction. d = cycles after the strobe cycle at which the
    // engine answers (>= TO means no answer inside the window).
    task automatic txn(input logic [N-1:0] r, input int nb, input int d,
                       input bit ackv, input bit drop, input bit abort);
        int w, kexp, got;
        logic [N-1:0] oh;
        bit e_ack, e_to;
        w  = rr_pick(r);
        oh = '0;
        oh[w] = 1'b1;
        kexp  = (d < TO) ? d + 1 : TO;
        e_ack = (d < TO) ? ackv : 1'b0;
        e_to  = (d >= TO);
        req = r;
        for (int i = 0; i < N; i++) req_adr[7*i +: 7] = adr[i];
        p_bsy = (nb > 0);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            chk("bsy_hold_gnt", gnt, 0);
            chk("bsy_hold_pstb", p_stb, 0);
        end
        p_bsy = 1'b0;
        @(negedge clk);
        chk("gnt", gnt, oh);
        chk("p_stb", p_stb, 1);
        chk("p_adr", p_adr, adr[w]);
        chk("bsy_issue", bsy, 1);
        got = -1;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("p_stb_pulse", p_stb, 0);
                if (drop) req[w] = 1'b0;
            end
            if (abort && k == 3) begin
                rst = 1'b1;
                #1;
                chk("arst_gnt", gnt, 0);
                chk("arst_bsy", bsy, 0);
                chk("arst_pstb", p_stb, 0);
                chk("arst_rsp", rsp_stb, 0);
                p_o_stb = 1'b0;
                @(negedge clk);
                chk("arst_rsp2", rsp_stb, 0);
                rst = 1'b0;
                last_gnt = N - 1;
                return;
            end
            if (rsp_stb != 0) begin
                got = k;
                p_o_stb = e_to;   // late result lands in the response cycle
                p_o_ack = 1'b1;
                break;
            end
            p_o_stb = (k == d);
            p_o_ack = ackv;
        end
        chk("rsp_lat", got, kexp);
        chk("rsp_stb", rsp_stb, oh);
        chk("rsp_gnt", gnt, oh);
        chk("rsp_ack", rsp_ack, e_ack);
        chk("rsp_to", rsp_to, e_to);
        @(negedge clk);
        p_o_stb = 1'b0;
        chk("post_rsp_stb", rsp_stb, 0);
        chk("post_gnt", gnt, 0);
        chk("post_bsy", bsy, 0);
        chk("hold_ack", rsp_ack, e_ack);
        chk("hold_to", rsp_to, e_to);
        last_gnt = w;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_adr = '0;
        p_bsy = 1'b0; p_o_stb = 1'b0; p_o_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp", rsp_stb, 0);
        chk("rst_bits", {rsp_ack, rsp_to, bsy, p_stb}, 0);
        chk("rst_adr", p_adr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin with all requesters active: 0,1,2,3,0
        for (int i = 0; i < N; i++) adr[i] = 7'h10 + 7'(i);
        for (int i = 0; i < 5; i++) txn('1, 0, 5, 1'b1, 1'b0, 1'b0);

        // Single request
        adr[0] = 7'h50;
        txn(4'b0001, 0, 10, 1'b1, 1'b0, 1'b0);
        // Timeouts: never answering, and answering only in the response cycle
        txn(4'b0100, 0, TO + 5, 1'b1, 1'b0, 1'b0);
        txn(4'b0100, 0, TO, 1'b1, 1'b0, 1'b0);
        // Result on the final counter cycle wins
        txn(4'b1000, 0, TO - 1, 1'b1, 1'b0, 1'b0);
        // Engine busy for 20 cycles
        txn(4'b0010, 20, 3, 1'b0, 1'b0, 1'b0);
        // Request dropped after grant still completes
        txn(4'b0001, 0, 2, 1'b0, 1'b1, 1'b0);
        // Reset mid-WAIT for requester 2, then 0 wins
        txn(4'b0100, 0, 8, 1'b1, 1'b0, 1'b1);
        txn(4'b0101, 0, 4, 1'b1, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) adr[i] = 7'($urandom);
            txn(r, $urandom_range(0, 3), $urandom_range(1, TO + 2),
                1'($urandom), 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
